// File: rtl/rf_wb_arbiter_pkg.sv
//==============================================================
// rf_wb_arbiter_pkg : shared constants for the writeback arbiter
// Rev 1.0
//==============================================================
`default_nettype none

package rf_wb_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LD   = 1;
  localparam int REQ_LINK = 2;
  localparam int REQ_MUL  = 3;

  localparam int RF_ZERO_ADDR = 0;

  // Pointer width; a single requester still needs a 1-bit pointer
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_priority_pick.sv
//==============================================================
// rr_priority_pick : rotating find-first, one-hot grant plus index
// Rev 1.0
//==============================================================
`default_nettype none

module rr_priority_pick
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  logic [NREQ-1:0] w_rot;
  logic [PW-1:0]   w_ff;
  logic [PW:0]     w_sum;

  // Bit k of w_rot is the requester k places after ptr
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_rot[k] = req_i[(int'(ptr_i) + k) % NREQ];
    end
  end

  always_comb begin
    w_ff = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_ff = PW'(k);
      end
    end
  end

  assign w_sum   = {1'b0, w_ff} + {1'b0, ptr_i};
  assign valid_o = |w_rot;

  always_comb begin
    idx_o = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : w_sum[PW-1:0];
    grant_o = valid_o ? (NREQ'(1) << idx_o) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
//==============================================================
// rf_wb_arbiter : round-robin share of the register-file write port
// Rev 1.0
//==============================================================
`default_nettype none

module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               busy
);

  localparam int PW = ptr_width(NREQ);

  logic [PW-1:0]   ptr_q,      ptr_d;
  logic            rf_we_q,    rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

  logic [NREQ-1:0] w_req_elig;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_valid;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  // Reset outranks hold, hold outranks requests: both simply blank eligibility
  assign w_req_elig = (rst || hold) ? '0 : req;

  rr_priority_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i   (w_req_elig),
    .ptr_i   (ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .valid_o (w_valid)
  );

  assign w_sel_addr = req_addr[w_idx*AW +: AW];
  assign w_sel_data = req_data[w_idx*DW +: DW];

  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (w_valid) begin
      ptr_d      = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      // r0 is hardwired: the transfer is acked but never written
      rf_we_d    = (w_sel_addr != AW'(RF_ZERO_ADDR));
      rf_waddr_d = w_sel_addr;
      rf_wdata_d = w_sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign ack      = w_grant;
  assign busy     = (|req) & ~(|w_grant);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
//==============================================================
// tb_rf_wb_arbiter : table-driven bench for the writeback arbiter
// Rev 1.0
//==============================================================
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [NREQ*AW-1:0] ADDR_STD = {5'd12, 5'd1, 5'd7, 5'd3};
  localparam logic [NREQ*AW-1:0] ADDR_R0  = {5'd12, 5'd1, 5'd7, 5'd0};
  localparam logic [NREQ*DW-1:0] DATA_STD = {32'hCAFEF00D, 32'h00001000, 32'hDEADBEEF, 32'hA0A00000};
  localparam logic [NREQ*DW-1:0] DATA_R0  = {32'hCAFEF00D, 32'h00001000, 32'hDEADBEEF, 32'h00001234};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               hold = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr = ADDR_STD;
  logic [NREQ*DW-1:0] req_data = DATA_STD;
  logic [NREQ-1:0]    ack;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy)
  );

  // One record per cycle; rf_* expectations are the registered values visible in that cycle
  typedef struct {
    logic            rst;
    logic            hold;
    logic [NREQ-1:0] req;
    logic            sel_r0;
    logic [NREQ-1:0] ack;
    logic            busy;
    logic            chk_rf;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_table();
    // rst hold req sel_r0 | ack busy chk_rf we waddr wdata
    vq.push_back('{1, 0, 4'b1111, 0, 4'b0000, 1, 0, 0, 5'd0,  32'h0});
    vq.push_back('{0, 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 5'd0,  32'h0});
    vq.push_back('{0, 0, 4'b0010, 0, 4'b0010, 0, 1, 0, 5'd0,  32'h0});
    vq.push_back('{0, 0, 4'b0000, 0, 4'b0000, 0, 1, 1, 5'd7,  32'hDEADBEEF});
    vq.push_back('{0, 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 5'd7,  32'hDEADBEEF});
    vq.push_back('{1, 0, 4'b1111, 0, 4'b0000, 1, 1, 0, 5'd7,  32'hDEADBEEF});
    vq.push_back('{0, 0, 4'b1111, 0, 4'b0001, 0, 1, 0, 5'd0,  32'h0});
    vq.push_back('{0, 0, 4'b1111, 0, 4'b0010, 0, 1, 1, 5'd3,  32'hA0A00000});
    vq.push_back('{0, 0, 4'b1111, 0, 4'b0100, 0, 1, 1, 5'd7,  32'hDEADBEEF});
    vq.push_back('{0, 0, 4'b1111, 0, 4'b1000, 0, 1, 1, 5'd1,  32'h00001000});
    vq.push_back('{0, 0, 4'b1111, 0, 4'b0001, 0, 1, 1, 5'd12, 32'hCAFEF00D});
    vq.push_back('{0, 0, 4'b1111, 0, 4'b0010, 0, 1, 1, 5'd3,  32'hA0A00000});
    vq.push_back('{0, 0, 4'b1111, 0, 4'b0100, 0, 1, 1, 5'd7,  32'hDEADBEEF});
    vq.push_back('{0, 0, 4'b1111, 0, 4'b1000, 0, 1, 1, 5'd1,  32'h00001000});
    vq.push_back('{0, 0, 4'b0000, 0, 4'b0000, 0, 1, 1, 5'd12, 32'hCAFEF00D});
    vq.push_back('{0, 0, 4'b0001, 1, 4'b0001, 0, 1, 0, 5'd12, 32'hCAFEF00D});
    vq.push_back('{0, 0, 4'b0000, 0, 4'b0000, 0, 1, 0, 5'd0,  32'h00001234});
    vq.push_back('{0, 1, 4'b0101, 0, 4'b0000, 1, 1, 0, 5'd0,  32'h00001234});
    vq.push_back('{0, 1, 4'b0101, 0, 4'b0000, 1, 1, 0, 5'd0,  32'h00001234});
    vq.push_back('{0, 1, 4'b0101, 0, 4'b0000, 1, 1, 0, 5'd0,  32'h00001234});
    vq.push_back('{0, 0, 4'b0101, 0, 4'b0100, 0, 1, 0, 5'd0,  32'h00001234});
    vq.push_back('{0, 0, 4'b0001, 0, 4'b0001, 0, 1, 1, 5'd1,  32'h00001000});
    vq.push_back('{0, 0, 4'b0000, 0, 4'b0000, 0, 1, 1, 5'd3,  32'hA0A00000});
  endtask

  initial begin
    bit seen;
    fill_table();

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst      = vq[i].rst;
      hold     = vq[i].hold;
      req      = vq[i].req;
      req_addr = vq[i].sel_r0 ? ADDR_R0 : ADDR_STD;
      req_data = vq[i].sel_r0 ? DATA_R0 : DATA_STD;
      #1;
      check($sformatf("v%0d.ack", i),  32'(ack),  32'(vq[i].ack));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(vq[i].busy));
      if (vq[i].chk_rf) begin
        check($sformatf("v%0d.rf_we", i),    32'(rf_we),    32'(vq[i].we));
        check($sformatf("v%0d.rf_waddr", i), 32'(rf_waddr), 32'(vq[i].waddr));
        check($sformatf("v%0d.rf_wdata", i), rf_wdata,      vq[i].wdata);
      end
    end

    // Reset arriving in the cycle of a grant: the grant vanishes and the pointer restarts at 0
    req_addr = ADDR_STD;
    req_data = DATA_STD;
    @(negedge clk);
    req = 4'b0001;
    #1 check("mid.pre_ack", 32'(ack), 32'h1);
    @(negedge clk);
    req = 4'b0100;
    #1 check("mid.ack2", 32'(ack), 32'h4);
    rst = 1'b1;
    #1 check("mid.ack_rst", 32'(ack), 32'h0);
    check("mid.busy_rst", 32'(busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1001;
    #1 check("mid.rf_we_after_rst", 32'(rf_we), 32'h0);
    check("mid.rf_waddr_after_rst", 32'(rf_waddr), 32'h0);
    check("mid.ack_from_ptr0", 32'(ack), 32'h1);
    @(negedge clk);
    req = 4'b0000;
    #1 check("mid.rf_we_post", 32'(rf_we), 32'h1);
    check("mid.rf_waddr_post", 32'(rf_waddr), 32'd3);

    // Fairness: pointer now at 1, so source 0 must win within NREQ cycles of full contention
    seen = 1'b0;
    for (int c = 0; c < NREQ && !seen; c++) begin
      @(negedge clk);
      req = 4'b1111;
      #1;
      if (ack[0]) begin
        seen = 1'b1;
        check("fair.cycle_of_src0", 32'(c), 32'd3);
      end
    end
    if (!seen) check("fair.src0_granted", 32'h0, 32'h1);
    @(negedge clk);
    req = 4'b0000;
    #1 check("fair.last_write_src0", 32'(rf_waddr), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
